hazard_stall_ctrl: RTL and testbench

// - Pipeline sequencing controller for the 5-stage RISC-V core. Sits beside the

---
 rtl/hazard_stall_ctrl_pkg.sv | 35 +++
 rtl/hazard_stall_ctrl_if.sv | 39 +++
 rtl/hazard_stall_ctrl_sat_counter.sv | 20 ++
 rtl/hazard_stall_ctrl.sv | 93 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_pkg: shared state encoding, register-index width and pipeline control words
package hazard_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic idex_write;
        logic exmem_write;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF      = 7'b0000000;
    localparam ctrl_t CTRL_NORMAL   = 7'b1100110;
    localparam ctrl_t CTRL_LOAD_USE = 7'b0001110;
    localparam ctrl_t CTRL_BRANCH   = 7'b1110110;
    localparam ctrl_t CTRL_FREEZE   = 7'b0000001;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    function automatic logic load_use(input logic memread, input logic [REG_W-1:0] rd,
                                      input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2);
        return memread && (rd != '0) && (rd == rs1 || rd == rs2);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline-status inputs and sequencing/counter outputs of the stall controller
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16) ();
    import hazard_pkg::*;

    logic             start_i;
    logic [REG_W-1:0] ID_rs1_i;
    logic [REG_W-1:0] ID_rs2_i;
    logic             EX_memread_i;
    logic [REG_W-1:0] EX_rd_i;
    logic             branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ack_i;
    logic             pc_write_o;
    logic             IFID_write_o;
    logic             IFID_flush_o;
    logic             IDEX_bubble_o;
    logic             IDEX_write_o;
    logic             EXMEM_write_o;
    logic             MEMWB_bubble_o;
    logic             halt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] freeze_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport slave (
        input  start_i, ID_rs1_i, ID_rs2_i, EX_memread_i, EX_rd_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        output pc_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, IDEX_write_o,
               EXMEM_write_o, MEMWB_bubble_o, halt_o, stall_cnt_o, freeze_cnt_o, flush_cnt_o
    );

    modport master (
        output start_i, ID_rs1_i, ID_rs2_i, EX_memread_i, EX_rd_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        input  pc_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, IDEX_write_o,
               EXMEM_write_o, MEMWB_bubble_o, halt_o, stall_cnt_o, freeze_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 16) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    // count one per asserted cycle until saturated
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i)
            r_cnt <= '0;
        else if (inc_i && r_cnt != '1)
            r_cnt <= r_cnt + W'(1);

    assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: per-cycle advance/hold/bubble/flush decisions for the 5-stage pipeline
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    hazard_stall_ctrl_if.slave bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            r_state, w_state_nxt;
    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
    logic              w_active, w_freeze, w_load_use, w_branch;
    ctrl_t             w_ctrl;

    // classify the cycle: memory freeze beats load-use, which beats a taken branch
    always_comb begin
        w_active   = (r_state == S_RUN) || (r_state == S_MEM_WAIT);
        w_freeze   = w_active && bus.dmem_req_i && !bus.dmem_ack_i;
        w_load_use = w_active && !w_freeze &&
                     load_use(bus.EX_memread_i, bus.EX_rd_i, bus.ID_rs1_i, bus.ID_rs2_i);
        w_branch   = w_active && !w_freeze && !w_load_use && bus.branch_taken_i;
        w_ctrl     = !w_active  ? CTRL_OFF      :
                     w_freeze   ? CTRL_FREEZE   :
                     w_load_use ? CTRL_LOAD_USE :
                     w_branch   ? CTRL_BRANCH   : CTRL_NORMAL;
    end

    // next state and memory-wait watchdog; HALT is only left through reset
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        case (r_state)
            S_IDLE:     if (bus.start_i) w_state_nxt = S_RUN;
            S_RUN:      if (w_freeze) begin
                            w_state_nxt = S_MEM_WAIT;
                            w_wait_nxt  = '0;
                        end
            S_MEM_WAIT: if (!w_freeze)
                            w_state_nxt = S_RUN;
                        else if (r_wait == WAIT_W'(MEM_TIMEOUT - 1))
                            w_state_nxt = S_HALT;
                        else
                            w_wait_nxt = r_wait + WAIT_W'(1);
            default:    ;
        endcase
    end

    // state and wait-counter registers
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end

    assign bus.pc_write_o     = w_ctrl.pc_write;
    assign bus.IFID_write_o   = w_ctrl.ifid_write;
    assign bus.IFID_flush_o   = w_ctrl.ifid_flush;
    assign bus.IDEX_bubble_o  = w_ctrl.idex_bubble;
    assign bus.IDEX_write_o   = w_ctrl.idex_write;
    assign bus.EXMEM_write_o  = w_ctrl.exmem_write;
    assign bus.MEMWB_bubble_o = w_ctrl.memwb_bubble;
    assign bus.halt_o         = (r_state == S_HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_load_use),
        .cnt_o (bus.stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_freeze),
        .cnt_o (bus.freeze_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_branch),
        .cnt_o (bus.flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scenarios for the stall controller with 2-bit counters and timeout 4
module tb_hazard_stall_ctrl;
    import hazard_pkg::*;

    localparam logic [6:0] C_OFF  = 7'b0000000;
    localparam logic [6:0] C_NORM = 7'b1100110;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_BR   = 7'b1110110;
    localparam logic [6:0] C_FRZ  = 7'b0000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [6:0] ctrl;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(2)) bus ();

    hazard_stall_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    assign ctrl = {bus.pc_write_o, bus.IFID_write_o, bus.IFID_flush_o, bus.IDEX_bubble_o,
                   bus.IDEX_write_o, bus.EXMEM_write_o, bus.MEMWB_bubble_o};

    task automatic drive(input logic memread, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic br, input logic req, input logic ack);
        bus.EX_memread_i   = memread;
        bus.EX_rd_i        = rd;
        bus.ID_rs1_i       = rs1;
        bus.ID_rs2_i       = rs2;
        bus.branch_taken_i = br;
        bus.dmem_req_i     = req;
        bus.dmem_ack_i     = ack;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start_i = 1'b1;
        drive(1, 5, 5, 5, 1, 1, 0);
        #3;
        checks++; if (ctrl !== C_OFF) begin errors++; $display("FAIL rst_ctrl: got %b expected %b", ctrl, C_OFF); end
        checks++; if (bus.halt_o !== 1'b0) begin errors++; $display("FAIL rst_halt: got %b expected 0", bus.halt_o); end
        checks++; if ({bus.stall_cnt_o, bus.freeze_cnt_o, bus.flush_cnt_o} !== 6'd0) begin errors++;
            $display("FAIL rst_cnt: got %b expected 000000", {bus.stall_cnt_o, bus.freeze_cnt_o, bus.flush_cnt_o}); end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (ctrl !== C_OFF) begin errors++; $display("FAIL idle_ctrl: got %b expected %b", ctrl, C_OFF); end
        tick();
        bus.start_i = 1'b0;
        #1;
        checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL run_ctrl: got %b expected %b", ctrl, C_NORM); end
    endtask

    task automatic test_branch;
        do_reset();
        drive(0, 5, 5, 5, 0, 0, 0); #1;
        checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL noload_ctrl: got %b expected %b", ctrl, C_NORM); end
        tick();
        drive(1, 5, 6, 7, 0, 0, 0); #1;
        checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL nomatch_ctrl: got %b expected %b", ctrl, C_NORM); end
        tick();
        drive(0, 0, 0, 0, 1, 0, 0); #1;
        checks++; if (ctrl !== C_BR) begin errors++; $display("FAIL br_ctrl: got %b expected %b", ctrl, C_BR); end
        tick();
        checks++; if ({bus.flush_cnt_o, bus.stall_cnt_o} !== 4'b0100) begin errors++;
            $display("FAIL br_cnt: got flush %0d stall %0d expected flush 1 stall 0", bus.flush_cnt_o, bus.stall_cnt_o); end
    endtask

    task automatic test_load_use;
        do_reset();
        drive(1, 5, 3, 5, 0, 0, 0); #1;
        checks++; if (ctrl !== C_LU) begin errors++; $display("FAIL lu_ctrl: got %b expected %b", ctrl, C_LU); end
        tick();
        checks++; if (bus.stall_cnt_o !== 2'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", bus.stall_cnt_o); end
        drive(0, 5, 3, 5, 0, 0, 0); #1;
        checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL lu_after: got %b expected %b", ctrl, C_NORM); end
        tick();
        drive(1, 7, 7, 0, 1, 0, 0); #1;
        checks++; if (ctrl !== C_LU) begin errors++; $display("FAIL lu_br_ctrl: got %b expected %b", ctrl, C_LU); end
        tick();
        checks++; if (bus.flush_cnt_o !== 2'd0) begin errors++; $display("FAIL lu_br_flush: got %0d expected 0", bus.flush_cnt_o); end
        drive(0, 7, 7, 0, 1, 0, 0); #1;
        checks++; if (ctrl !== C_BR) begin errors++; $display("FAIL lu_br_retry: got %b expected %b", ctrl, C_BR); end
        tick();
        checks++; if ({bus.stall_cnt_o, bus.flush_cnt_o} !== 4'b1001) begin errors++;
            $display("FAIL lu_br_cnt: got stall %0d flush %0d expected stall 2 flush 1", bus.stall_cnt_o, bus.flush_cnt_o); end
    endtask

    task automatic test_rd_zero;
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL rd0_ctrl: got %b expected %b", ctrl, C_NORM); end
        tick();
        checks++; if (bus.stall_cnt_o !== 2'd0) begin errors++; $display("FAIL rd0_cnt: got %0d expected 0", bus.stall_cnt_o); end
    endtask

    task automatic test_mem_freeze;
        do_reset();
        drive(0, 0, 0, 0, 1, 1, 0); #1;
        checks++; if (ctrl !== C_FRZ) begin errors++; $display("FAIL frz1_ctrl: got %b expected %b", ctrl, C_FRZ); end
        tick();
        drive(1, 5, 5, 0, 1, 1, 0); #1;
        checks++; if (ctrl !== C_FRZ) begin errors++; $display("FAIL frz2_ctrl: got %b expected %b", ctrl, C_FRZ); end
        tick();
        drive(0, 0, 0, 0, 1, 1, 0); #1;
        checks++; if (ctrl !== C_FRZ) begin errors++; $display("FAIL frz3_ctrl: got %b expected %b", ctrl, C_FRZ); end
        tick();
        drive(0, 0, 0, 0, 1, 1, 1); #1;
        checks++; if (ctrl !== C_BR) begin errors++; $display("FAIL frz_ack_ctrl: got %b expected %b", ctrl, C_BR); end
        tick();
        checks++; if ({bus.freeze_cnt_o, bus.flush_cnt_o, bus.stall_cnt_o} !== 6'b110100) begin errors++;
            $display("FAIL frz_cnt: got freeze %0d flush %0d stall %0d expected 3 1 0",
                     bus.freeze_cnt_o, bus.flush_cnt_o, bus.stall_cnt_o); end
        checks++; if (bus.halt_o !== 1'b0) begin errors++; $display("FAIL frz_halt: got %b expected 0", bus.halt_o); end
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL frz_resume: got %b expected %b", ctrl, C_NORM); end
    endtask

    task automatic test_ack_first;
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 1); #1;
        checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL ack1_ctrl: got %b expected %b", ctrl, C_NORM); end
        tick();
        checks++; if (bus.freeze_cnt_o !== 2'd0) begin errors++; $display("FAIL ack1_cnt: got %0d expected 0", bus.freeze_cnt_o); end
    endtask

    task automatic test_timeout;
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (ctrl !== C_FRZ) begin errors++; $display("FAIL to_ctrl[%0d]: got %b expected %b", i, ctrl, C_FRZ); end
            checks++; if (bus.halt_o !== 1'b0) begin errors++; $display("FAIL to_early_halt[%0d]: got %b expected 0", i, bus.halt_o); end
            tick();
        end
        bus.start_i = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0); #1;
        checks++; if (bus.halt_o !== 1'b1) begin errors++; $display("FAIL to_halt: got %b expected 1", bus.halt_o); end
        checks++; if (ctrl !== C_OFF) begin errors++; $display("FAIL to_halt_ctrl: got %b expected %b", ctrl, C_OFF); end
        checks++; if (bus.freeze_cnt_o !== 2'd3) begin errors++; $display("FAIL to_freeze_cnt: got %0d expected 3", bus.freeze_cnt_o); end
        tick();
        checks++; if (bus.halt_o !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", bus.halt_o); end
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset_mid_freeze;
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ctrl !== C_OFF) begin errors++; $display("FAIL midrst_ctrl: got %b expected %b", ctrl, C_OFF); end
        checks++; if (bus.freeze_cnt_o !== 2'd0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", bus.freeze_cnt_o); end
    endtask

    task automatic test_saturation;
        logic [1:0] exp;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            exp = (k > 3) ? 2'd3 : 2'(k);
            drive(1, 5, 5, 0, 0, 0, 0); #1;
            checks++; if (ctrl !== C_LU) begin errors++; $display("FAIL sat_ctrl[%0d]: got %b expected %b", k, ctrl, C_LU); end
            tick();
            checks++; if (bus.stall_cnt_o !== exp) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, bus.stall_cnt_o, exp); end
            drive(0, 5, 5, 0, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_branch();
        test_load_use();
        test_rd_zero();
        test_mem_freeze();
        test_ack_first();
        test_timeout();
        test_reset_mid_freeze();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
